chart_sequencer: RTL and testbench

//  Parametrised successor to the fixed 4-lane chart step reader. Walks a chart ROM of
//  {arrows, timing} entries under beat control. Counts down each entry's timing in beats,

---
 rtl/chart_sequencer.sv | 136 +++++++++++++
 tb/tb_chart_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chart_sequencer.sv
// Chart step sequencer: walks a chart ROM of {arrows, timing} entries, counts each
// entry's timing down in beats, then emits a one-cycle launch of its arrow mask.
module chart_sequencer #(
  parameter int LANES_P    = 4,
  parameter int TIMING_W_P = 4,
  parameter int ADDR_W_P   = 7,
  parameter int DEPTH_P    = 128,
  parameter int LOOP_P     = 0
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic                          pause_i,
  input  logic                          beat_i,
  output logic [ADDR_W_P-1:0]           rd_addr_o,
  input  logic [LANES_P+TIMING_W_P-1:0] rd_data_i,
  output logic [LANES_P-1:0]            launch_o,
  output logic                          launch_valid_o,
  output logic                          busy_o,
  output logic                          done_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_DONE} state_t;

  localparam logic [ADDR_W_P-1:0]   LAST_ADDR = ADDR_W_P'(DEPTH_P - 1);
  localparam logic [TIMING_W_P-1:0] ONE_BEAT  = TIMING_W_P'(1);

  state_t                r_state;
  logic [ADDR_W_P-1:0]   r_addr;
  logic [TIMING_W_P-1:0] r_count;
  logic [LANES_P-1:0]    r_arrows;
  logic [LANES_P-1:0]    r_launch;
  logic                  r_launch_valid;
  logic                  r_busy;
  logic                  r_done;

  state_t                w_state_nxt;
  logic [ADDR_W_P-1:0]   w_addr_nxt;
  logic [TIMING_W_P-1:0] w_count_nxt;
  logic [LANES_P-1:0]    w_arrows_nxt;
  logic [LANES_P-1:0]    w_launch_nxt;
  logic                  w_launch_valid_nxt;
  logic                  w_beat_ok;
  logic                  w_is_end;
  logic [LANES_P-1:0]    w_rom_arrows;
  logic [TIMING_W_P-1:0] w_rom_timing;

  assign w_beat_ok    = beat_i & ~pause_i;
  assign w_is_end     = (rd_data_i == '0);
  assign w_rom_arrows = rd_data_i[LANES_P+TIMING_W_P-1:TIMING_W_P];
  assign w_rom_timing = rd_data_i[TIMING_W_P-1:0];

  always_comb begin
    // NOTE: every next-state signal is given its hold value first so no path leaves it unassigned (no latches).
    w_state_nxt        = r_state;
    w_addr_nxt         = r_addr;
    w_count_nxt        = r_count;
    w_arrows_nxt       = r_arrows;
    w_launch_nxt       = '0;
    w_launch_valid_nxt = 1'b0;

    if (start_i) begin
      // Restart beats any beat arriving in the same cycle.
      w_state_nxt = ST_LOAD;
      w_addr_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      unique case (r_state)
        ST_LOAD: begin
          if (!pause_i) begin
            if (w_is_end) begin
              if (LOOP_P != 0 && r_addr != '0) w_addr_nxt = '0;
              else                             w_state_nxt = ST_DONE;
            end else begin
              w_arrows_nxt = w_rom_arrows;
              w_count_nxt  = w_rom_timing;
              w_state_nxt  = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_beat_ok) begin
            if (r_count <= ONE_BEAT) begin
              w_launch_nxt       = r_arrows;
              w_launch_valid_nxt = 1'b1;
              if (r_addr == LAST_ADDR) begin
                if (LOOP_P != 0) begin
                  w_addr_nxt  = '0;
                  w_state_nxt = ST_LOAD;
                end else begin
                  w_state_nxt = ST_DONE;
                end
              end else begin
                w_addr_nxt  = r_addr + ADDR_W_P'(1);
                w_state_nxt = ST_LOAD;
              end
            end else begin
              w_count_nxt = r_count - ONE_BEAT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state        <= ST_IDLE;
      r_addr         <= '0;
      r_count        <= '0;
      r_arrows       <= '0;
      r_launch       <= '0;
      r_launch_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_addr         <= w_addr_nxt;
      r_count        <= w_count_nxt;
      r_arrows       <= w_arrows_nxt;
      r_launch       <= w_launch_nxt;
      r_launch_valid <= w_launch_valid_nxt;
      r_busy         <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_WAIT);
      r_done         <= (w_state_nxt == ST_DONE);
    end
  end

  assign rd_addr_o      = r_addr;
  assign launch_o       = r_launch;
  assign launch_valid_o = r_launch_valid;
  assign busy_o         = r_busy;
  assign done_o         = r_done;

endmodule

// File: tb/tb_chart_sequencer.sv
// Bench for chart_sequencer: a stop-at-end instance (depth 128) and a looping
// instance (depth 2) share stimulus and are each tracked by a beat-counting model.
module tb_chart_sequencer;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic reset_i, start_i, pause_i, beat_i;

  logic [7:0] rom0 [128];
  logic [7:0] rom1 [2];

  logic [6:0] addr0;
  logic [7:0] data0;
  logic [3:0] launch0;
  logic       lv0, busy0, done0;

  logic [0:0] addr1;
  logic [7:0] data1;
  logic [3:0] launch1;
  logic       lv1, busy1, done1;

  assign data0 = rom0[addr0];
  assign data1 = rom1[addr1];

  chart_sequencer #(.LANES_P(4), .TIMING_W_P(4), .ADDR_W_P(7), .DEPTH_P(128), .LOOP_P(0)) u_dut0 (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .pause_i(pause_i), .beat_i(beat_i),
    .rd_addr_o(addr0), .rd_data_i(data0), .launch_o(launch0), .launch_valid_o(lv0),
    .busy_o(busy0), .done_o(done0));

  chart_sequencer #(.LANES_P(4), .TIMING_W_P(4), .ADDR_W_P(1), .DEPTH_P(2), .LOOP_P(1)) u_dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .pause_i(pause_i), .beat_i(beat_i),
    .rd_addr_o(addr1), .rd_data_i(data1), .launch_o(launch1), .launch_valid_o(lv1),
    .busy_o(busy1), .done_o(done1));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: an entry of timing T needs max(T,1) accepted beats; beats are counted up.
  typedef struct {
    bit       loading, waiting, done;
    int       addr, need, seen;
    bit [3:0] arrows;
    bit       lv;
    bit [3:0] lm;
  } mdl_t;
  mdl_t m [2];

  function automatic logic [7:0] rom_rd(input int k, input int a);
    return (k == 0) ? rom0[a] : rom1[a % 2];
  endfunction

  task automatic model_step(input int k, input bit rst, input bit st, input bit ps, input bit bt);
    int   depth = (k == 0) ? 128 : 2;
    bit   loop  = (k == 1);
    logic [7:0] e;
    m[k].lv = 1'b0;
    m[k].lm = '0;
    if (rst) begin
      m[k].loading = 0; m[k].waiting = 0; m[k].done = 0;
      m[k].addr = 0; m[k].need = 0; m[k].seen = 0; m[k].arrows = '0;
    end else if (st) begin
      m[k].loading = 1; m[k].waiting = 0; m[k].done = 0;
      m[k].addr = 0; m[k].seen = 0;
    end else if (ps && (m[k].loading || m[k].waiting)) begin
      // frozen
    end else if (m[k].loading) begin
      e = rom_rd(k, m[k].addr);
      if (e == 8'h00) begin
        if (loop && m[k].addr != 0) m[k].addr = 0;
        else begin m[k].loading = 0; m[k].done = 1; end
      end else begin
        m[k].arrows  = e[7:4];
        m[k].need    = (e[3:0] == 0) ? 1 : int'(e[3:0]);
        m[k].seen    = 0;
        m[k].loading = 0;
        m[k].waiting = 1;
      end
    end else if (m[k].waiting && bt) begin
      m[k].seen++;
      if (m[k].seen >= m[k].need) begin
        m[k].lv = 1'b1;
        m[k].lm = m[k].arrows;
        m[k].waiting = 0;
        if (m[k].addr == depth - 1) begin
          if (loop) begin m[k].addr = 0; m[k].loading = 1; end
          else m[k].done = 1;
        end else begin
          m[k].addr++;
          m[k].loading = 1;
        end
      end
    end
  endtask

  task automatic compare_models();
    check("d0_addr",   32'(addr0),   32'(m[0].addr));
    check("d0_valid",  32'(lv0),     32'(m[0].lv));
    check("d0_launch", 32'(launch0), 32'(m[0].lm));
    check("d0_busy",   32'(busy0),   32'(m[0].loading | m[0].waiting));
    check("d0_done",   32'(done0),   32'(m[0].done));
    check("d1_addr",   32'(addr1),   32'(m[1].addr));
    check("d1_valid",  32'(lv1),     32'(m[1].lv));
    check("d1_launch", 32'(launch1), 32'(m[1].lm));
    check("d1_busy",   32'(busy1),   32'(m[1].loading | m[1].waiting));
    check("d1_done",   32'(done1),   32'(m[1].done));
  endtask

  task automatic tick(input bit rst, input bit st, input bit ps, input bit bt);
    @(negedge clk_i);
    reset_i = rst; start_i = st; pause_i = ps; beat_i = bt;
    @(posedge clk_i);
    model_step(0, rst, st, ps, bt);
    model_step(1, rst, st, ps, bt);
    #1;
    compare_models();
  endtask

  task automatic want(input string tag, input bit v, input logic [3:0] l, input int a,
                      input bit b, input bit d);
    check({tag, "_valid"},  32'(lv0),     32'(v));
    check({tag, "_launch"}, 32'(launch0), 32'(l));
    check({tag, "_addr"},   32'(addr0),   32'(a));
    check({tag, "_busy"},   32'(busy0),   32'(b));
    check({tag, "_done"},   32'(done0),   32'(d));
  endtask

  typedef struct {
    bit st, ps, bt;
    bit lv; logic [3:0] lm; int addr; bit busy, done;
  } vec_t;
  vec_t tbl [14];

  logic [3:0] loop_q [$];
  bit         prev_beat;

  initial begin
    reset_i = 1'b1; start_i = 1'b0; pause_i = 1'b0; beat_i = 1'b0;
    foreach (rom0[i]) rom0[i] = 8'h00;
    rom0[0] = 8'h53;
    rom1[0] = 8'h31;
    rom1[1] = 8'hC2;

    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    want("reset", 0, 4'h0, 0, 0, 0);

    // Single entry {0101,3} then end marker, beats every 4 cycles.
    tbl[0]  = '{1,0,0, 0,4'h0,0,1,0};
    tbl[1]  = '{0,0,0, 0,4'h0,0,1,0};
    tbl[2]  = '{0,0,1, 0,4'h0,0,1,0};
    tbl[3]  = '{0,0,0, 0,4'h0,0,1,0};
    tbl[4]  = '{0,0,0, 0,4'h0,0,1,0};
    tbl[5]  = '{0,0,0, 0,4'h0,0,1,0};
    tbl[6]  = '{0,0,1, 0,4'h0,0,1,0};
    tbl[7]  = '{0,0,0, 0,4'h0,0,1,0};
    tbl[8]  = '{0,0,0, 0,4'h0,0,1,0};
    tbl[9]  = '{0,0,0, 0,4'h0,0,1,0};
    tbl[10] = '{0,0,1, 1,4'h5,1,1,0};
    tbl[11] = '{0,0,0, 0,4'h0,1,0,1};
    tbl[12] = '{0,0,1, 0,4'h0,1,0,1};
    tbl[13] = '{1,0,0, 0,4'h0,0,1,0};
    for (int i = 0; i < 14; i++) begin
      tick(0, tbl[i].st, tbl[i].ps, tbl[i].bt);
      want($sformatf("tbl%0d", i), tbl[i].lv, tbl[i].lm, tbl[i].addr, tbl[i].busy, tbl[i].done);
    end

    // Reset in the middle of WAIT, then beats must not launch anything.
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    want("rst_wait", 0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 1);
      want("rst_beat", 0, 4'h0, 0, 0, 0);
      tick(0, 0, 0, 0);
    end

    // Timing 0 and timing 1 both launch on the first beat after their LOAD.
    rom0[0] = 8'h80; rom0[1] = 8'h21; rom0[2] = 8'h00;
    tick(0, 1, 0, 0); want("t01_start", 0, 4'h0, 0, 1, 0);
    tick(0, 0, 0, 0); want("t01_load0", 0, 4'h0, 0, 1, 0);
    tick(0, 0, 0, 1); want("t01_launch0", 1, 4'h8, 1, 1, 0);
    tick(0, 0, 0, 0); want("t01_load1", 0, 4'h0, 1, 1, 0);
    tick(0, 0, 0, 1); want("t01_launch1", 1, 4'h2, 2, 1, 0);
    tick(0, 0, 0, 0); want("t01_done", 0, 4'h0, 2, 0, 1);

    // Paused beats are ignored; two unpaused beats are still needed.
    rom0[0] = 8'h12; rom0[1] = 8'h00;
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 1); want("pause_b1", 0, 4'h0, 0, 1, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 1); want("pause_b2", 0, 4'h0, 0, 1, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 1); want("pause_u1", 0, 4'h0, 0, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1); want("pause_u2", 1, 4'h1, 1, 1, 0);
    tick(0, 0, 0, 0); want("pause_done", 0, 4'h0, 1, 0, 1);

    // Start coinciding with the final beat cancels the launch.
    rom0[0] = 8'h41;
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 1); want("st_beat", 0, 4'h0, 0, 1, 0);
    tick(0, 0, 0, 0); want("st_beat_wait", 0, 4'h0, 0, 1, 0);

    // Looping depth-2 chart alternates entries and never finishes.
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    for (int i = 0; i < 90; i++) begin
      tick(0, 0, 0, (i % 3) == 0);
      if (lv1) loop_q.push_back(launch1);
    end
    check("loop_count_ok", 32'(loop_q.size() >= 6), 32'd1);
    foreach (loop_q[i]) check($sformatf("loop_seq%0d", i), 32'(loop_q[i]), (i % 2 == 0) ? 32'h3 : 32'hC);
    check("loop_not_done", 32'(done1), 32'd0);

    // Random chart with scattered end markers and random start/pause/reset.
    foreach (rom0[i]) begin
      rom0[i] = {4'($urandom), 4'($urandom_range(0, 3))};
      if ($urandom_range(0, 29) == 0) rom0[i] = 8'h00;
      else if (rom0[i] == 8'h00) rom0[i] = 8'h10;
    end
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    prev_beat = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit bt;
      bt = !prev_beat && ($urandom_range(0, 1) == 1);
      tick($urandom_range(0, 599) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 4) == 0, bt);
      prev_beat = bt;
    end

    // Full 128-entry chart with no end marker stops in DONE at the last address.
    foreach (rom0[i]) rom0[i] = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 2))};
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    for (int i = 0; i < 4000 && !m[0].done; i++) tick(0, 0, 0, (i % 2) == 0);
    check("end_done", 32'(done0), 32'd1);
    check("end_addr", 32'(addr0), 32'd127);
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, (i % 2) == 0);
      want("end_hold", 0, 4'h0, 127, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
